// File: rtl/debounce_pkg.sv
// Shared defaults and counter sizing for the key debounce bank.
// Imported by debounce_channel and debounce_bank.
package debounce_pkg;

    localparam int DEPTH_DEF         = 10;
    localparam int REPEAT_DELAY_DEF  = 30;
    localparam int REPEAT_PERIOD_DEF = 6;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced key: 2-flop synchroniser, sample counter, state, event pulses.
// Ports: CLK, NRST (sync, active-low), CLK_EN sample tick, key_in raw level,
//        key_out debounced level, key_press / key_release one-CLK events.
// Optional auto-repeat of key_press when DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic CLK,
    input  logic NRST,
    input  logic CLK_EN,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
        $error("debounce_channel: DEPTH and repeat timings must be >= 1");
    end

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          state_q, state_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] rpt_q,   rpt_d;
    logic [RW-1:0] rpt_nxt;
    logic          first_q, first_d;
`endif

    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
        rpt_d   = rpt_q;
        first_d = first_q;
        rpt_nxt = rpt_q + 1'b1;
`endif
        if (CLK_EN) begin
            // An agreeing sample aborts any pending transition.
            if (sync2_q == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEPTH - 1)) begin
                state_d = sync2_q;
                cnt_d   = '0;
                press_d = sync2_q;
                rel_d   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef DEBOUNCE_REPEAT_EN
            // First repeat waits REPEAT_DELAY ticks, later ones
            // REPEAT_PERIOD; a release commit wins over a repeat.
            if (press_d) begin
                rpt_d   = '0;
                first_d = 1'b1;
            end else if (state_q && !rel_d) begin
                if (( first_q && rpt_nxt == RW'(REPEAT_DELAY)) ||
                    (!first_q && rpt_nxt == RW'(REPEAT_PERIOD))) begin
                    press_d = 1'b1;
                    rpt_d   = '0;
                    first_d = 1'b0;
                end else begin
                    rpt_d = rpt_nxt;
                end
            end else begin
                rpt_d   = '0;
                first_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rpt_q   <= '0;
            first_q <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef DEBOUNCE_REPEAT_EN
            rpt_q   <= rpt_d;
            first_q <= first_d;
`endif
        end
    end

    assign key_out     = state_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_KEYS independent debouncers for the board push-buttons.
// Ports: CLK, NRST (sync, active-low), CLK_EN sample tick, key_in[N_KEYS],
//        key_out / key_press / key_release per key.
// Define DEBOUNCE_REPEAT_EN to enable held-key auto-repeat press pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic              CLK,
    input  logic              NRST,
    input  logic              CLK_EN,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        debounce_channel #(
            .DEPTH         (DEPTH),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .CLK         (CLK),
            .NRST        (NRST),
            .CLK_EN      (CLK_EN),
            .key_in      (key_in[k]),
            .key_out     (key_out[k]),
            .key_press   (key_press[k]),
            .key_release (key_release[k])
        );
    end

endmodule
